// File: rtl/rf_commit_serializer.sv
// Commit serializer: accepts up to two retired results per cycle, buffers them in
// program order and drains them to the single-write-port register file one per cycle.
module rf_commit_serializer #(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 4,
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clr_in,
  input  logic                   c0_valid,
  input  logic [ROB_IDX_W-1:0]   c0_rob_index,
  input  logic [REG_IDX_W-1:0]   c0_rd,
  input  logic [DATA_W-1:0]      c0_val,
  input  logic                   c1_valid,
  input  logic [ROB_IDX_W-1:0]   c1_rob_index,
  input  logic [REG_IDX_W-1:0]   c1_rd,
  input  logic [DATA_W-1:0]      c1_val,
  output logic                   commit_ready,
  output logic                   reg_commit,
  output logic [ROB_IDX_W-1:0]   reg_rob_index,
  output logic [REG_IDX_W-1:0]   reg_index,
  output logic [DATA_W-1:0]      reg_val,
  input  logic [REG_IDX_W-1:0]   lk_rs1_pos,
  input  logic [REG_IDX_W-1:0]   lk_rs2_pos,
  output logic                   lk_rs1_hit,
  output logic                   lk_rs2_hit,
  output logic [DATA_W-1:0]      lk_rs1_val,
  output logic [DATA_W-1:0]      lk_rs2_val,
  output logic                   drained,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [REG_IDX_W-1:0] r_rd  [DEPTH];
  logic [ROB_IDX_W-1:0] r_rob [DEPTH];
  logic [DATA_W-1:0]    r_val [DEPTH];
  logic                 r_commit;
  logic [ROB_IDX_W-1:0] r_out_rob;
  logic [REG_IDX_W-1:0] r_out_rd;
  logic [DATA_W-1:0]    r_out_val;

  logic                 w_ready;
  logic                 w_en0;
  logic                 w_en1;
  logic                 w_pop;
  logic [PW-1:0]        w_slot1;
  logic [REG_IDX_W-1:0] w_lk_pos [2];
  logic                 w_lk_hit [2];
  logic [DATA_W-1:0]    w_lk_val [2];
  logic                 w_unused_clr;

  // Flush never discards anything here: buffered entries are already architectural.
  assign w_unused_clr = clr_in;

  assign w_ready = rdy_in && (r_count <= CW'(DEPTH - 2));
  assign w_en0   = w_ready && c0_valid && (c0_rd != '0);
  assign w_en1   = w_ready && c1_valid && (c1_rd != '0);
  assign w_pop   = rdy_in && (r_count != '0);
  assign w_slot1 = r_tail + PW'(w_en0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_commit  <= 1'b0;
      r_out_rob <= '0;
      r_out_rd  <= '0;
      r_out_val <= '0;
    end else if (rdy_in) begin
      r_tail  <= r_tail + PW'(w_en0) + PW'(w_en1);
      r_count <= r_count + CW'(w_en0) + CW'(w_en1) - CW'(w_pop);
      if (w_pop) begin
        r_head    <= r_head + PW'(1);
        r_commit  <= 1'b1;
        r_out_rob <= r_rob[r_head];
        r_out_rd  <= r_rd[r_head];
        r_out_val <= r_val[r_head];
      end else begin
        r_commit <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_en0) begin
      r_rd[r_tail]  <= c0_rd;
      r_rob[r_tail] <= c0_rob_index;
      r_val[r_tail] <= c0_val;
    end
    if (w_en1) begin
      r_rd[w_slot1]  <= c1_rd;
      r_rob[w_slot1] <= c1_rob_index;
      r_val[w_slot1] <= c1_val;
    end
  end

  assign w_lk_pos[0] = lk_rs1_pos;
  assign w_lk_pos[1] = lk_rs2_pos;

  // Scan oldest to youngest so the youngest matching write is the one that sticks.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_lk_hit[p] = 1'b0;
      w_lk_val[p] = '0;
      if (w_lk_pos[p] != '0) begin
        if (r_commit && (r_out_rd == w_lk_pos[p])) begin
          w_lk_hit[p] = 1'b1;
          w_lk_val[p] = r_out_val;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < r_count) && (r_rd[r_head + PW'(i)] == w_lk_pos[p])) begin
            w_lk_hit[p] = 1'b1;
            w_lk_val[p] = r_val[r_head + PW'(i)];
          end
        end
      end
    end
  end

  assign lk_rs1_hit    = w_lk_hit[0];
  assign lk_rs1_val    = w_lk_val[0];
  assign lk_rs2_hit    = w_lk_hit[1];
  assign lk_rs2_val    = w_lk_val[1];
  assign commit_ready  = w_ready;
  assign reg_commit    = r_commit;
  assign reg_rob_index = r_out_rob;
  assign reg_index     = r_out_rd;
  assign reg_val       = r_out_val;
  assign drained       = (r_count == '0) && !r_commit;
  assign count         = r_count;

endmodule

// File: tb/tb_rf_commit_serializer.sv
// Directed bench for rf_commit_serializer: ordering, backpressure, lookup, stall and reset.
module tb_rf_commit_serializer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        c0_valid, c1_valid;
  logic [3:0]  c0_rob_index, c1_rob_index;
  logic [4:0]  c0_rd, c1_rd;
  logic [31:0] c0_val, c1_val;
  logic        commit_ready, reg_commit;
  logic [3:0]  reg_rob_index;
  logic [4:0]  reg_index;
  logic [31:0] reg_val;
  logic [4:0]  lk_rs1_pos, lk_rs2_pos;
  logic        lk_rs1_hit, lk_rs2_hit;
  logic [31:0] lk_rs1_val, lk_rs2_val;
  logic        drained;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  bit track   = 1'b0;
  int exp_next;

  always #5 clk_in = ~clk_in;

  rf_commit_serializer #(.DEPTH(4), .ROB_IDX_W(4), .REG_IDX_W(5), .DATA_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .c0_valid(c0_valid), .c0_rob_index(c0_rob_index), .c0_rd(c0_rd), .c0_val(c0_val),
    .c1_valid(c1_valid), .c1_rob_index(c1_rob_index), .c1_rd(c1_rd), .c1_val(c1_val),
    .commit_ready(commit_ready), .reg_commit(reg_commit), .reg_rob_index(reg_rob_index),
    .reg_index(reg_index), .reg_val(reg_val),
    .lk_rs1_pos(lk_rs1_pos), .lk_rs2_pos(lk_rs2_pos),
    .lk_rs1_hit(lk_rs1_hit), .lk_rs2_hit(lk_rs2_hit),
    .lk_rs1_val(lk_rs1_val), .lk_rs2_val(lk_rs2_val),
    .drained(drained), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (track && reg_commit) begin
      chk("order_rd", 64'(reg_index), 64'(exp_next));
      chk("order_val", 64'(reg_val), 64'(exp_next * 17));
      chk("order_rob", 64'(reg_rob_index), 64'(exp_next[3:0]));
      exp_next++;
    end
  endtask

  task automatic slot0(input logic v, input int rob, input int rd, input int val);
    c0_valid = v; c0_rob_index = 4'(rob); c0_rd = 5'(rd); c0_val = 32'(val);
  endtask

  task automatic slot1(input logic v, input int rob, input int rd, input int val);
    c1_valid = v; c1_rob_index = 4'(rob); c1_rd = 5'(rd); c1_val = 32'(val);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; clr_in = 1'b0;
    slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
    lk_rs1_pos = '0; lk_rs2_pos = '0;
    #12;
    chk("rst_commit", 64'(reg_commit), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_drained", 64'(drained), 1);
    chk("rst_index", 64'(reg_index), 0);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick();
    chk("idle_commit", 64'(reg_commit), 0);
    chk("idle_drained", 64'(drained), 1);
    chk("idle_ready", 64'(commit_ready), 1);
    chk("idle_count", 64'(count), 0);

    // Single commit
    slot0(1, 3, 5, 32'h1234);
    lk_rs1_pos = 5;
    tick();
    slot0(0, 0, 0, 0);
    chk("s_count", 64'(count), 1);
    chk("s_commit0", 64'(reg_commit), 0);
    chk("s_lk_buf_hit", 64'(lk_rs1_hit), 1);
    chk("s_lk_buf_val", 64'(lk_rs1_val), 64'h1234);
    tick();
    chk("s_commit", 64'(reg_commit), 1);
    chk("s_index", 64'(reg_index), 5);
    chk("s_val", 64'(reg_val), 64'h1234);
    chk("s_rob", 64'(reg_rob_index), 3);
    chk("s_lk_out_hit", 64'(lk_rs1_hit), 1);
    tick();
    chk("s_commit_off", 64'(reg_commit), 0);
    chk("s_drained", 64'(drained), 1);
    chk("s_lk_miss", 64'(lk_rs1_hit), 0);
    chk("s_lk_miss_val", 64'(lk_rs1_val), 0);
    chk("s_hold_index", 64'(reg_index), 5);

    // Dual retire stream rd 1..8 with backpressure
    exp_next = 1;
    track = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 10 && !commit_ready; w++) tick();
      chk("cr_wait", 64'(commit_ready), 1);
      slot0(1, 2*k+1, 2*k+1, (2*k+1)*17);
      slot1(1, 2*k+2, 2*k+2, (2*k+2)*17);
      tick();
      slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
      if (k == 1) begin
        chk("cr_drop", 64'(commit_ready), 0);
        chk("cr_count3", 64'(count), 3);
      end
    end
    for (int w = 0; w < 20 && !drained; w++) tick();
    track = 1'b0;
    chk("stream_drained", 64'(drained), 1);
    chk("stream_all", 64'(exp_next), 9);

    // Same register written twice in one cycle
    slot0(1, 1, 7, 32'hA);
    slot1(1, 2, 7, 32'hB);
    lk_rs1_pos = 7; lk_rs2_pos = 0;
    tick();
    slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
    chk("bb_hit0", 64'(lk_rs1_hit), 1);
    chk("bb_val0", 64'(lk_rs1_val), 64'hB);
    chk("bb_rs2_0", 64'(lk_rs2_hit), 0);
    tick();
    chk("bb_out_a", 64'(reg_val), 64'hA);
    chk("bb_val1", 64'(lk_rs1_val), 64'hB);
    tick();
    chk("bb_out_b", 64'(reg_val), 64'hB);
    chk("bb_hit2", 64'(lk_rs1_hit), 1);
    chk("bb_val2", 64'(lk_rs1_val), 64'hB);
    chk("bb_rs2_2", 64'(lk_rs2_hit), 0);
    tick();
    chk("bb_miss", 64'(lk_rs1_hit), 0);
    chk("bb_miss_val", 64'(lk_rs1_val), 0);
    chk("bb_drained", 64'(drained), 1);

    // Stall with three buffered entries and a flush pulse
    slot0(1, 10, 10, 10*17); slot1(1, 11, 11, 11*17);
    tick();
    slot0(1, 12, 12, 12*17); slot1(1, 13, 13, 13*17);
    tick();
    slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
    chk("st_count", 64'(count), 3);
    chk("st_out", 64'(reg_index), 10);
    rdy_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      clr_in = (c == 2);
      tick();
      chk("st_ready", 64'(commit_ready), 0);
      chk("st_hold_cnt", 64'(count), 3);
      chk("st_hold_out", 64'(reg_index), 10);
      chk("st_hold_cmt", 64'(reg_commit), 1);
    end
    clr_in = 1'b0;
    rdy_in = 1'b1;
    exp_next = 11;
    track = 1'b1;
    tick();
    tick();
    tick();
    track = 1'b0;
    chk("st_drain_all", 64'(exp_next), 14);
    chk("st_count0", 64'(count), 0);
    tick();
    chk("st_drained", 64'(drained), 1);

    // rd 0 is discarded
    slot0(1, 2, 2, 32'h22); slot1(1, 4, 0, 32'hFF);
    tick();
    slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
    chk("z_count", 64'(count), 1);
    tick();
    chk("z_commit", 64'(reg_commit), 1);
    chk("z_index", 64'(reg_index), 2);
    tick();
    chk("z_single", 64'(reg_commit), 0);

    // Asynchronous reset mid-drain
    slot0(1, 3, 3, 32'h33); slot1(1, 4, 4, 32'h44);
    tick();
    slot0(0, 0, 0, 0); slot1(0, 0, 0, 0);
    tick();
    chk("ar_pre_commit", 64'(reg_commit), 1);
    chk("ar_pre_count", 64'(count), 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("ar_commit", 64'(reg_commit), 0);
    chk("ar_count", 64'(count), 0);
    chk("ar_index", 64'(reg_index), 0);
    chk("ar_drained", 64'(drained), 1);
    rst_in = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
